// File: rtl/reg_file.sv
// reg_file: RV64I integer register file, x1..x31 stored, x0 hard-wired to zero.
// Two datapath read ports (rs1, rs2), one write port, one debug read port.
// Optional macro REGFILE_BYPASS_EN forwards the in-flight write to rs1/rs2.
module reg_file #(
    parameter int unsigned          XLEN    = 64,
    parameter logic [XLEN-1:0]      SP_INIT = 64'h0000_0000_0000_3FF0,
    parameter logic [XLEN-1:0]      GP_INIT = 64'h0000_0000_0000_1800
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            we_i,
    input  logic [4:0]      dbg_addr_i,
    output logic [XLEN-1:0] dbg_data_o
);

    logic [XLEN-1:0] regs_q [1:31];
    logic [XLEN-1:0] regs_d [1:31];
    logic [XLEN-1:0] rs1_raw;
    logic [XLEN-1:0] rs2_raw;

    // Next-state: at most the one addressed register takes the write data.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (we_i && (rd_addr_i == 5'(i))) begin
                regs_d[i] = rd_data_i;
            end
        end
    end

    // Storage; reset loads the stack and global pointers, everything else clears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 2) begin
                    regs_q[i] <= SP_INIT;
                end else if (i == 3) begin
                    regs_q[i] <= GP_INIT;
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Stored-value read mux for all three ports; index 0 falls through to zero.
    always_comb begin
        rs1_raw    = '0;
        rs2_raw    = '0;
        dbg_data_o = '0;
        for (int i = 1; i < 32; i++) begin
            if (rs1_addr_i == 5'(i)) rs1_raw    = regs_q[i];
            if (rs2_addr_i == 5'(i)) rs2_raw    = regs_q[i];
            if (dbg_addr_i == 5'(i)) dbg_data_o = regs_q[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_fwd;
    assign wr_fwd = rst_ni && we_i && (rd_addr_i != 5'd0);

    // Forward the pending write to the datapath ports; debug always sees storage.
    always_comb begin
        rs1_data_o = (wr_fwd && (rd_addr_i == rs1_addr_i)) ? rd_data_i : rs1_raw;
        rs2_data_o = (wr_fwd && (rd_addr_i == rs2_addr_i)) ? rd_data_i : rs2_raw;
    end
`else
    // Without forwarding the datapath ports return stored contents only.
    always_comb begin
        rs1_data_o = rs1_raw;
        rs2_data_o = rs2_raw;
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized bench for reg_file against an array reference model.
module tb_reg_file;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
    logic [63:0] rs1_data, rs2_data, rd_data, dbg_data;
    logic        we;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mdl [32];

    reg_file dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rs1_addr_i (rs1_addr),
        .rs2_addr_i (rs2_addr),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data),
        .rd_addr_i  (rd_addr),
        .rd_data_i  (rd_data),
        .we_i       (we),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
        mdl[2] = 64'h3FF0;
        mdl[3] = 64'h1800;
    endtask

    // Architectural view of a read port given the current drive.
    function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit fwd_ok);
        if (a == 5'd0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
        if (fwd_ok && rst_n && we && rd_addr == a) return rd_data;
`endif
        return mdl[a];
    endfunction

    task automatic check_ports(input string ph);
        chk({ph, "_rs1"}, rs1_data, exp_rd(rs1_addr, 1'b1));
        chk({ph, "_rs2"}, rs2_data, exp_rd(rs2_addr, 1'b1));
        chk({ph, "_dbg"}, dbg_data, exp_rd(dbg_addr, 1'b0));
    endtask

    // Drive one cycle from just after a falling edge, check before and after the rising edge.
    task automatic step(input logic w, input logic [4:0] rd, input logic [63:0] d,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        we = w; rd_addr = rd; rd_data = d;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
        #1;
        check_ports("pre");
        @(posedge clk);
        if (w && rd != 5'd0) mdl[rd] = d;
        #1;
        check_ports("post");
        @(negedge clk);
    endtask

    task automatic check_all_dbg(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk(tag, dbg_data, (i == 0) ? 64'h0 : mdl[i]);
        end
    endtask

    initial begin
        clk_en = 1'b0;
        rst_n = 1'b1; we = 1'b0;
        rd_addr = '0; rd_data = '0; rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
        #1 rst_n = 1'b0;
        #1;
        // Reset values with no clock running.
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("rst_dbg", dbg_data, (i == 2) ? 64'h3FF0 : (i == 3) ? 64'h1800 : 64'h0);
        end
        model_reset();
        rst_n = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);

        // Basic write/read.
        step(1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567, 5'd1, 5'd2, 5'd5);
        step(1'b0, 5'd0, 64'h0, 5'd5, 5'd5, 5'd5);
        chk("x5_rs1", rs1_data, 64'hDEAD_BEEF_0123_4567);
        chk("x5_rs2", rs2_data, 64'hDEAD_BEEF_0123_4567);

        // x0 protection.
        step(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0, 5'd0);
        chk("x0_rs1", rs1_data, 64'h0);
        check_all_dbg("x0_others");

        // Same-cycle read/write on x7.
        step(1'b1, 5'd7, 64'h1, 5'd0, 5'd0, 5'd7);
        we = 1'b1; rd_addr = 5'd7; rd_data = 64'h2; rs1_addr = 5'd7; dbg_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("raw_pre_rs1", rs1_data, 64'h2);
`else
        chk("raw_pre_rs1", rs1_data, 64'h1);
`endif
        chk("raw_pre_dbg", dbg_data, 64'h1);
        @(posedge clk);
        mdl[7] = 64'h2;
        #1;
        chk("raw_post_rs1", rs1_data, 64'h2);
        chk("raw_post_dbg", dbg_data, 64'h2);
        @(negedge clk);

        // Write gating.
        repeat (3) step(1'b0, 5'd9, 64'hAAAA, 5'd9, 5'd9, 5'd9);
        chk("gate_x9", dbg_data, 64'h0);

        // Reset in the middle of a write cycle.
        step(1'b1, 5'd4, 64'h55, 5'd4, 5'd4, 5'd4);
        we = 1'b1; rd_addr = 5'd4; rd_data = 64'h77; rs1_addr = 5'd4; dbg_addr = 5'd4;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_dbg_now", dbg_data, 64'h0);
        chk("mrst_rs1_now", rs1_data, 64'h0);
        chk("mrst_sp", dut.rs2_data_o, (rs2_addr == 5'd4) ? 64'h0 : 64'h0);
        @(posedge clk);
        #1;
        chk("mrst_dbg_edge", dbg_data, 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        mdl[4] = 64'h77;
        #1;
        chk("mrst_after_rel", dbg_data, 64'h77);
        @(negedge clk);
        check_all_dbg("mrst_all");

        // Randomized traffic, biased toward read-after-write collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  r, a1, a2, ad;
            logic [63:0] d;
            r  = 5'($urandom_range(0, 31));
            d  = {$urandom, $urandom};
            a1 = ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31));
            ad = ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), r, d, a1, a2, ad);
        end
        check_all_dbg("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
